// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Two-port (CPU, I/O) arbiter/sequencer for a single-port RAM with acked,
// variable-latency transactions. Define MEM_PORT_ARB_RR_EN for round-robin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] wait_cnt;
    logic       grant_io;

`ifdef MEM_PORT_ARB_RR_EN
    logic last_owner;

    // On contention the port that was not granted last time wins.
    always_comb grant_io = io_req && (!cpu_req || !last_owner);
`else
    logic last_owner;

    always_comb grant_io = io_req && !cpu_req;
    always_comb last_owner = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= S_IDLE;
            wait_cnt  <= 3'd0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            io_rdata  <= '0;
            io_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
`ifdef MEM_PORT_ARB_RR_EN
            last_owner <= 1'b1;
`endif
        end else begin
            cpu_ack <= 1'b0;
            io_ack  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_req || io_req) begin
                        owner     <= grant_io;
`ifdef MEM_PORT_ARB_RR_EN
                        last_owner <= grant_io;
`endif
                        mem_en    <= 1'b1;
                        mem_we    <= grant_io ? io_we    : cpu_we;
                        mem_addr  <= grant_io ? io_addr  : cpu_addr;
                        mem_wdata <= grant_io ? io_wdata : cpu_wdata;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // mem_we still holds the latched direction during the issue cycle.
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        cpu_ack <= !owner;
                        io_ack  <= owner;
                        state   <= S_ACK;
                    end else begin
                        wait_cnt <= LAT;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        if (owner) begin
                            io_rdata <= mem_rdata;
                            io_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level
// model (arbitration rule, latency formula, shadow memory).
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int LAT = 3;

    logic          clock = 1'b0;
    logic          clear = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          io_req = 1'b0, io_we = 1'b0;
    logic [AW-1:0] io_addr = '0;
    logic [DW-1:0] io_wdata = '0;
    logic [DW-1:0] io_rdata;
    logic          io_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, owner;

    int n_checks = 0;
    int n_fail   = 0;

    // Device-side RAM: writes land at the issue edge, read data appears LAT cycles later.
    logic [DW-1:0] ram       [2**AW];
    bit            ram_valid [2**AW];
    logic [DW-1:0] pipe      [LAT];

    // Reference model state.
    logic [DW-1:0] exp_mem   [2**AW];
    bit            exp_valid [2**AW];
    logic [DW-1:0] exp_cpu_rdata = '0;
    logic [DW-1:0] exp_io_rdata  = '0;
    bit            model_last    = 1'b1;

    always #5 clock = ~clock;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clock(clock), .clear(clear),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_ack(io_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 'h1FF) return 32'h12345678;
        return 32'hA5000000 ^ (32'(a) * 32'h00010203);
    endfunction

    assign mem_rdata = pipe[LAT-1];

    always @(posedge clock) begin
        if (mem_en && !mem_we)
            pipe[0] <= ram_valid[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
        else
            pipe[0] <= 32'hBAD0BAD0;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        if (mem_en && mem_we) begin
            ram[mem_addr]       <= mem_wdata;
            ram_valid[mem_addr] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int a);
        return exp_valid[a] ? exp_mem[a] : init_word(a);
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(9'h1F8, 9'h1FF));
        return AW'($urandom_range(0, 7));
    endfunction

    // Checks the current IDLE cycle(s); ends #1 after the next rising edge.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            check("idle_busy", busy, 0);
            check("idle_mem_en", mem_en, 0);
            check("idle_acks", {cpu_ack, io_ack}, 0);
            @(posedge clock); #1;
        end
    endtask

    // Called #1 into an IDLE cycle with requests already presented.
    task automatic run_txn(input bit drop_req, output bit win);
        bit            we_l;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            ack_cyc;
        if (cpu_req && io_req) begin
`ifdef MEM_PORT_ARB_RR_EN
            win = !model_last;
`else
            win = 1'b0;
`endif
        end else begin
            win = io_req;
        end
        model_last = win;
        we_l    = win ? io_we    : cpu_we;
        a       = win ? io_addr  : cpu_addr;
        d       = win ? io_wdata : cpu_wdata;
        ack_cyc = we_l ? 2 : 2 + LAT;

        @(negedge clock);
        check("c0_busy", busy, 0);
        check("c0_mem_en", mem_en, 0);
        for (int c = 1; c <= ack_cyc; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                // Latched request must be immune to later input changes.
                if (win) begin
                    io_we = ~io_we; io_addr = rand_addr(); io_wdata = $urandom;
                    if (drop_req && $urandom_range(0, 1) == 1) io_req = 1'b0;
                end else begin
                    cpu_we = ~cpu_we; cpu_addr = rand_addr(); cpu_wdata = $urandom;
                    if (drop_req && $urandom_range(0, 1) == 1) cpu_req = 1'b0;
                end
            end
            @(negedge clock);
            check("mem_en", mem_en, (c == 1) ? 1 : 0);
            check("mem_we", mem_we, (c == 1) ? we_l : 1'b0);
            if (c == 1) begin
                check("mem_addr", mem_addr, a);
                check("mem_wdata", mem_wdata, d);
            end
            check("busy", busy, 1);
            check("owner", owner, win);
            if (c == ack_cyc && !we_l) begin
                if (win) exp_io_rdata  = model_read(int'(a));
                else     exp_cpu_rdata = model_read(int'(a));
            end
            check("cpu_ack", cpu_ack, (c == ack_cyc && !win) ? 1 : 0);
            check("io_ack", io_ack, (c == ack_cyc && win) ? 1 : 0);
            check("cpu_rdata", cpu_rdata, exp_cpu_rdata);
            check("io_rdata", io_rdata, exp_io_rdata);
        end
        if (we_l) begin
            exp_mem[int'(a)]   = d;
            exp_valid[int'(a)] = 1'b1;
        end
        @(posedge clock); #1;
        if (drop_req) begin
            if (win) io_req = 1'b0;
            else     cpu_req = 1'b0;
        end
    endtask

    initial begin
        bit w;
        bit [2:0] grants;
        bit [2:0] exp_grants;

        repeat (2) @(posedge clock);
        #1 clear = 1'b1;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_io_rdata", io_rdata, 0);
        check("rst_acks", {cpu_ack, io_ack}, 0);
        @(posedge clock); #1;
        idle_cycles(4);

        // Both ports held continuously for three grants.
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h020; cpu_wdata = 32'h0000C0DE;
        io_req  = 1; io_we  = 1; io_addr  = 9'h021; io_wdata  = 32'h00001111;
        for (int t = 0; t < 3; t++) begin
            run_txn(1'b0, w);
            grants[t] = w;
        end
        cpu_req = 0; io_req = 0;
`ifdef MEM_PORT_ARB_RR_EN
        exp_grants = 3'b010;
`else
        exp_grants = 3'b000;
`endif
        check("contention_grants", grants, exp_grants);
        idle_cycles(2);

        // CPU write then read-back.
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF;
        run_txn(1'b1, w);
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        run_txn(1'b1, w);
        check("cpu_readback", cpu_rdata, 32'hDEADBEEF);
        check("io_untouched", io_rdata, 0);

        // I/O read of the top address; data must hold after ack.
        io_req = 1; io_we = 0; io_addr = 9'h1FF;
        run_txn(1'b1, w);
        idle_cycles(2);
        check("io_rdata_hold", io_rdata, 32'h12345678);

        // Reset during WAIT abandons the transaction.
        io_req = 1; io_we = 0; io_addr = 9'h010;
        @(posedge clock); #1;
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock); #1;
        clear = 1'b1; io_req = 1'b0;
        exp_cpu_rdata = '0; exp_io_rdata = '0; model_last = 1'b1;
        @(negedge clock);
        check("mrst_busy", busy, 0);
        check("mrst_mem_en", mem_en, 0);
        check("mrst_io_rdata", io_rdata, 0);
        check("mrst_cpu_rdata", cpu_rdata, 0);
        @(posedge clock); #1;
        idle_cycles(LAT + 2);
        check("mrst_io_rdata_after", io_rdata, 0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        run_txn(1'b1, w);
        check("post_rst_read", cpu_rdata, 32'hDEADBEEF);

        // Randomized traffic.
        for (int it = 0; it < 80; it++) begin
            if (!cpu_req && !io_req && $urandom_range(0, 3) == 0)
                idle_cycles($urandom_range(1, 3));
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = rand_addr(); cpu_wdata = $urandom;
            end
            if (!io_req && $urandom_range(0, 1) == 1) begin
                io_req = 1; io_we = 1'($urandom_range(0, 1));
                io_addr = rand_addr(); io_wdata = $urandom;
            end
            if (!cpu_req && !io_req) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = rand_addr();
            end
            run_txn($urandom_range(0, 3) != 0, w);
        end
        cpu_req = 0; io_req = 0;
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
